// File: rtl/mccu_pkg.sv
// Shared definitions for the handshaking multicycle MIPS control unit:
// state encodings, opcode/func fields, ALU codes, datapath select codes
// and the decoded instruction-class record.
package mccu_pkg;

   // FSM state encodings (6 and 7 are unreachable and behave as IF)
   localparam logic [2:0] S_IF  = 3'd0;
   localparam logic [2:0] S_ID  = 3'd1;
   localparam logic [2:0] S_EXE = 3'd2;
   localparam logic [2:0] S_MEM = 3'd3;
   localparam logic [2:0] S_WB  = 3'd4;
   localparam logic [2:0] S_ERR = 3'd5;

   // Primary opcodes, inst[31:26]
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // R-type function codes, inst[5:0]
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_XOR = 6'b100110;
   localparam logic [5:0] FN_SLL = 6'b000000;
   localparam logic [5:0] FN_SRL = 6'b000010;
   localparam logic [5:0] FN_SRA = 6'b000011;
   localparam logic [5:0] FN_JR  = 6'b001000;

   // ALU operation codes
   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0100;
   localparam logic [3:0] ALU_AND = 4'b0001;
   localparam logic [3:0] ALU_OR  = 4'b0101;
   localparam logic [3:0] ALU_XOR = 4'b0010;
   localparam logic [3:0] ALU_LUI = 4'b0110;
   localparam logic [3:0] ALU_SLL = 4'b0011;
   localparam logic [3:0] ALU_SRL = 4'b0111;
   localparam logic [3:0] ALU_SRA = 4'b1111;

   // ALU B-operand selects
   localparam logic [1:0] BSEL_REGB  = 2'b00;
   localparam logic [1:0] BSEL_FOUR  = 2'b01;
   localparam logic [1:0] BSEL_IMM   = 2'b10;
   localparam logic [1:0] BSEL_BROFF = 2'b11;

   // Next-PC selects
   localparam logic [1:0] PCS_ALU  = 2'b00;
   localparam logic [1:0] PCS_REGC = 2'b01;
   localparam logic [1:0] PCS_QA   = 2'b10;
   localparam logic [1:0] PCS_JPC  = 2'b11;

   // One-hot instruction class; all zero means an unsupported encoding
   typedef struct packed {
      logic rAdd;
      logic rSub;
      logic rAnd;
      logic rOr;
      logic rXor;
      logic rSll;
      logic rSrl;
      logic rSra;
      logic rJr;
      logic iAddi;
      logic iAndi;
      logic iOri;
      logic iXori;
      logic iLui;
      logic iLw;
      logic iSw;
      logic iBeq;
      logic iBne;
      logic jJ;
      logic jJal;
   } instr_t;

   // ALU operation used in EXE for a decoded instruction
   function automatic logic [3:0] aluOp(input instr_t c);
      logic [3:0] r;
      r = ALU_ADD;
      if (c.rSub || c.iBeq || c.iBne) r = ALU_SUB;
      else if (c.rAnd || c.iAndi)     r = ALU_AND;
      else if (c.rOr  || c.iOri)      r = ALU_OR;
      else if (c.rXor || c.iXori)     r = ALU_XOR;
      else if (c.iLui)                r = ALU_LUI;
      else if (c.rSll)                r = ALU_SLL;
      else if (c.rSrl)                r = ALU_SRL;
      else if (c.rSra)                r = ALU_SRA;
      return r;
   endfunction

endpackage

// File: rtl/mccu_decode.sv
// Combinational instruction decoder: turns op/func into one-hot
// instruction classes and a flag saying the encoding is supported.
module mccu_decode
   import mccu_pkg::*;
(
   input  logic [5:0] i_op,
   input  logic [5:0] i_func,
   output instr_t     o_cls,
   output logic       o_legal
);

   // Map the opcode (and func for R-type) onto exactly one class bit
   always_comb begin
      o_cls = '0;
      case (i_op)
         OP_RTYPE: begin
            case (i_func)
               FN_ADD:  o_cls.rAdd = 1'b1;
               FN_SUB:  o_cls.rSub = 1'b1;
               FN_AND:  o_cls.rAnd = 1'b1;
               FN_OR:   o_cls.rOr  = 1'b1;
               FN_XOR:  o_cls.rXor = 1'b1;
               FN_SLL:  o_cls.rSll = 1'b1;
               FN_SRL:  o_cls.rSrl = 1'b1;
               FN_SRA:  o_cls.rSra = 1'b1;
               FN_JR:   o_cls.rJr  = 1'b1;
               default: o_cls = '0;
            endcase
         end
         OP_ADDI: o_cls.iAddi = 1'b1;
         OP_ANDI: o_cls.iAndi = 1'b1;
         OP_ORI:  o_cls.iOri  = 1'b1;
         OP_XORI: o_cls.iXori = 1'b1;
         OP_LUI:  o_cls.iLui  = 1'b1;
         OP_LW:   o_cls.iLw   = 1'b1;
         OP_SW:   o_cls.iSw   = 1'b1;
         OP_BEQ:  o_cls.iBeq  = 1'b1;
         OP_BNE:  o_cls.iBne  = 1'b1;
         OP_J:    o_cls.jJ    = 1'b1;
         OP_JAL:  o_cls.jJal  = 1'b1;
         default: o_cls = '0;
      endcase
   end

   assign o_legal = |o_cls;

endmodule

// File: rtl/mccu_hs.sv
// Multicycle MIPS control unit with a ready-based memory handshake,
// a per-access bus watchdog and sticky illegal-opcode / bus-error traps.
// Only the state, wait counter and error flags are registered; every
// control output is decoded combinationally from the current state.
module mccu_hs
   import mccu_pkg::*;
#(
   parameter int MEM_HANDSHAKE = 1,
   parameter int TIMEOUT       = 16,
   parameter int TO_W          = 8
)(
   input  logic       clock,
   input  logic       resetn,
   input  logic [5:0] op,
   input  logic [5:0] func,
   input  logic       z,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       wpc,
   output logic       wir,
   output logic       wmem,
   output logic       wreg,
   output logic       iord,
   output logic       regrt,
   output logic       m2reg,
   output logic       shift,
   output logic       selpc,
   output logic       jal,
   output logic       sext,
   output logic [3:0] aluc,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsource,
   output logic [2:0] state,
   output logic       bus_err,
   output logic       ill_op
);

   logic [2:0]      r_state;
   logic [TO_W-1:0] r_waitCnt;
   logic            r_busErr;
   logic            r_illOp;

   instr_t          w_cls;
   logic            w_legal;
   logic            w_rdy;
   logic            w_memAccess;
   logic            w_trip;
   logic            w_iType;
   logic            w_branch;
   logic [2:0]      w_next;
   logic            w_wpc;
   logic            w_wir;
   logic            w_wmem;
   logic            w_wreg;

   mccu_decode u_decode (
      .i_op    (op),
      .i_func  (func),
      .o_cls   (w_cls),
      .o_legal (w_legal)
   );

   // Without the handshake the memory is assumed to finish every access at once
   assign w_rdy = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

   // IF and MEM are the only states that talk to memory; the unreachable
   // encodings 6 and 7 behave as IF and so count as a memory access too
   assign w_memAccess = (r_state == S_IF) || (r_state == S_MEM) || (r_state > S_ERR);

   // The watchdog fires on the last allowed wait cycle; a ready on that cycle wins
   assign w_trip = (TIMEOUT != 0) && w_memAccess && !w_rdy &&
                   (r_waitCnt == TO_W'(TIMEOUT - 1));

   assign w_iType  = w_cls.iAddi | w_cls.iAndi | w_cls.iOri | w_cls.iXori |
                     w_cls.iLui  | w_cls.iLw   | w_cls.iSw;
   assign w_branch = w_cls.iBeq | w_cls.iBne;

   // Per-state control decode and next-state selection
   always_comb begin
      w_next   = r_state;
      mem_req  = 1'b0;
      w_wpc    = 1'b0;
      w_wir    = 1'b0;
      w_wmem   = 1'b0;
      w_wreg   = 1'b0;
      iord     = 1'b0;
      regrt    = 1'b0;
      m2reg    = 1'b0;
      shift    = 1'b0;
      selpc    = 1'b0;
      jal      = 1'b0;
      sext     = 1'b0;
      aluc     = ALU_ADD;
      alusrcb  = BSEL_REGB;
      pcsource = PCS_ALU;
      case (r_state)
         S_ID: begin
            selpc   = 1'b1;
            alusrcb = BSEL_BROFF;
            if (w_cls.jJ || w_cls.jJal) begin
               w_wpc    = 1'b1;
               pcsource = PCS_JPC;
               w_wreg   = w_cls.jJal;
               jal      = w_cls.jJal;
               w_next   = S_IF;
            end else if (w_cls.rJr) begin
               w_wpc    = 1'b1;
               pcsource = PCS_QA;
               w_next   = S_IF;
            end else if (!w_legal) begin
               w_next = S_ERR;
            end else begin
               w_next = S_EXE;
            end
         end
         S_EXE: begin
            sext  = w_cls.iAddi | w_cls.iLw | w_cls.iSw | w_branch;
            shift = w_cls.rSll | w_cls.rSrl | w_cls.rSra;
            aluc  = aluOp(w_cls);
            if (w_iType) alusrcb = BSEL_IMM;
            if (w_branch) begin
               alusrcb  = BSEL_REGB;
               w_wpc    = (w_cls.iBeq & z) | (w_cls.iBne & ~z);
               pcsource = PCS_REGC;
               w_next   = S_IF;
            end else if (w_cls.iLw || w_cls.iSw) begin
               w_next = S_MEM;
            end else begin
               w_next = S_WB;
            end
         end
         S_MEM: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            w_wmem  = w_cls.iSw;
            if (w_rdy)       w_next = w_cls.iLw ? S_WB : S_IF;
            else if (w_trip) w_next = S_ERR;
         end
         S_WB: begin
            w_wreg = 1'b1;
            regrt  = w_iType;
            m2reg  = w_cls.iLw;
            w_next = S_IF;
         end
         S_ERR: begin
            w_next = S_ERR;
         end
         default: begin
            mem_req = 1'b1;
            selpc   = 1'b1;
            alusrcb = BSEL_FOUR;
            w_wir   = w_rdy;
            w_wpc   = w_rdy;
            if (w_rdy)       w_next = S_ID;
            else if (w_trip) w_next = S_ERR;
         end
      endcase
   end

   // State register and wait counter; the counter restarts on every new access
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state   <= S_IF;
         r_waitCnt <= '0;
      end else begin
         r_state <= w_next;
         if ((TIMEOUT != 0) && w_memAccess && !w_rdy && !w_trip)
            r_waitCnt <= r_waitCnt + TO_W'(1);
         else
            r_waitCnt <= '0;
      end
   end

   // Sticky error flags, cleared only by reset
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_busErr <= 1'b0;
         r_illOp  <= 1'b0;
      end else begin
         if (w_trip)
            r_busErr <= 1'b1;
         if ((r_state == S_ID) && !w_legal)
            r_illOp <= 1'b1;
      end
   end

   // Write enables are held off while reset is asserted
   assign wpc  = w_wpc  & resetn;
   assign wir  = w_wir  & resetn;
   assign wmem = w_wmem & resetn;
   assign wreg = w_wreg & resetn;

   assign state   = r_state;
   assign bus_err = r_busErr;
   assign ill_op  = r_illOp;

endmodule
